// File: rtl/dmem_bus_ctrl.sv
// rtl/dmem_bus_ctrl.sv - data-side bus controller: valid/ready requests decoded to RAM, MMIO page or error
// One request in flight; RAM reads wait RAM_LAT cycles before the single response pulse.
module dmem_bus_ctrl #(
    parameter int          RAM_AW    = 10,
    parameter int          RAM_LAT   = 1,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter int          GPIO_N    = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [GPIO_N-1:0] gpio_out,
    input  logic [GPIO_N-1:0] gpio_in,
    output logic              timer_irq
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q;
    logic               req_ready_q;
    logic               resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;
    logic               ram_en_q;
    logic [3:0]         ram_we_q;
    logic [RAM_AW-1:0]  ram_addr_q;
    logic [31:0]        ram_wdata_q;
    logic [3:0]         be_q;
    logic [2:0]         wait_q;
    logic [GPIO_N-1:0]  gpio_out_q, gpio_out_d;
    logic [GPIO_N-1:0]  gpio_sync1_q, gpio_sync2_q;
    logic [31:0]        tmr_cnt_q, tmr_cnt_d;
    logic [31:0]        tmr_cmp_q, tmr_cmp_d;
    logic               tmr_en_q, tmr_en_d;
    logic               tmr_pend_q, tmr_pend_d;

    logic               accept;
    logic               is_ram;
    logic               is_mmio;
    logic               off_ok;
    logic               mmio_wr;
    logic [11:0]        off;
    logic [31:0]        mmio_rdata;
    logic [31:0]        gpio_out_ext;
    logic [31:0]        gpio_in_ext;

    function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    always_comb begin
        accept       = req_valid && req_ready_q;
        is_ram       = (req_addr >> (RAM_AW + 2)) == 32'd0;
        is_mmio      = req_addr[31:12] == MMIO_BASE[31:12];
        off          = {req_addr[11:2], 2'b00};
        gpio_out_ext = '0;
        gpio_out_ext[GPIO_N-1:0] = gpio_out_q;
        gpio_in_ext  = '0;
        gpio_in_ext[GPIO_N-1:0]  = gpio_sync2_q;

        off_ok     = 1'b1;
        mmio_rdata = '0;
        case (off)
            12'h000: mmio_rdata = gpio_out_ext;
            12'h004: mmio_rdata = gpio_in_ext;
            12'h008: mmio_rdata = tmr_cnt_q;
            12'h00C: mmio_rdata = tmr_cmp_q;
            12'h010: mmio_rdata = {30'd0, tmr_pend_q, tmr_en_q};
            default: off_ok = 1'b0;
        endcase

        // MMIO writes land on the accept edge so the effect is visible in the RESP cycle
        mmio_wr    = accept && !is_ram && is_mmio && off_ok && (req_be != 4'b0000);
        gpio_out_d = gpio_out_q;
        tmr_cnt_d  = tmr_en_q ? tmr_cnt_q + 32'd1 : tmr_cnt_q;
        tmr_cmp_d  = tmr_cmp_q;
        tmr_en_d   = tmr_en_q;
        tmr_pend_d = tmr_pend_q;
        if (mmio_wr) begin
            case (off)
                12'h000: begin
                    for (int i = 0; i < GPIO_N; i++) begin
                        if (req_be[i/8]) gpio_out_d[i] = req_wdata[i];
                    end
                end
                12'h008: tmr_cnt_d = be_merge(tmr_cnt_q, req_wdata, req_be);
                12'h00C: tmr_cmp_d = be_merge(tmr_cmp_q, req_wdata, req_be);
                12'h010: begin
                    if (req_be[0]) begin
                        tmr_en_d = req_wdata[0];
                        if (req_wdata[1]) tmr_pend_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        if (tmr_en_q && tmr_cnt_q == tmr_cmp_q) tmr_pend_d = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            be_q         <= '0;
            wait_q       <= '0;
            gpio_out_q   <= '0;
            gpio_sync1_q <= '0;
            gpio_sync2_q <= '0;
            tmr_cnt_q    <= '0;
            tmr_cmp_q    <= '0;
            tmr_en_q     <= 1'b0;
            tmr_pend_q   <= 1'b0;
        end else begin
            gpio_out_q   <= gpio_out_d;
            gpio_sync1_q <= gpio_in;
            gpio_sync2_q <= gpio_sync1_q;
            tmr_cnt_q    <= tmr_cnt_d;
            tmr_cmp_q    <= tmr_cmp_d;
            tmr_en_q     <= tmr_en_d;
            tmr_pend_q   <= tmr_pend_d;
            resp_valid_q <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= '0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        be_q        <= req_be;
                        ram_addr_q  <= req_addr[RAM_AW+1:2];
                        ram_wdata_q <= req_wdata;
                        if (is_ram) begin
                            state_q  <= S_ISSUE;
                            ram_en_q <= 1'b1;
                            ram_we_q <= req_be;
                        end else begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= !(is_mmio && off_ok);
                            resp_rdata_q <= (is_mmio && off_ok && req_be == 4'b0000) ? mmio_rdata : 32'd0;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (be_q != 4'b0000) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end else begin
                        state_q <= S_WAIT;
                        wait_q  <= 3'(RAM_LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (wait_q == 3'd0) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= ram_rdata;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign gpio_out   = gpio_out_q;
    assign timer_irq  = tmr_pend_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// tb/tb_dmem_bus_ctrl.sv - randomized self-checking bench for dmem_bus_ctrl against a transaction-level model
module tb_dmem_bus_ctrl;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic [3:0]  req_be    [2];
    logic [31:0] req_wdata [2];
    logic        resp_valid[2];
    logic [31:0] resp_rdata[2];
    logic        resp_err  [2];
    logic        ram_en    [2];
    logic [3:0]  ram_we    [2];
    logic [9:0]  ram_addr  [2];
    logic [31:0] ram_wdata [2];
    logic [31:0] ram_rdata [2];
    logic [7:0]  gpio_out  [2];
    logic [7:0]  gpio_in   [2];
    logic        timer_irq [2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        localparam int LAT = (d == 0) ? LAT0 : LAT1;
        logic [31:0] mem  [1024];
        logic [31:0] pipe [LAT];

        dmem_bus_ctrl #(
            .RAM_AW   (10),
            .RAM_LAT  (LAT),
            .MMIO_BASE(32'h1000_0000),
            .GPIO_N   (8)
        ) u_dut (
            .sys_clk   (clk),
            .sys_rst_n (rst_n),
            .req_valid (req_valid[d]),
            .req_ready (req_ready[d]),
            .req_addr  (req_addr[d]),
            .req_be    (req_be[d]),
            .req_wdata (req_wdata[d]),
            .resp_valid(resp_valid[d]),
            .resp_rdata(resp_rdata[d]),
            .resp_err  (resp_err[d]),
            .ram_en    (ram_en[d]),
            .ram_we    (ram_we[d]),
            .ram_addr  (ram_addr[d]),
            .ram_wdata (ram_wdata[d]),
            .ram_rdata (ram_rdata[d]),
            .gpio_out  (gpio_out[d]),
            .gpio_in   (gpio_in[d]),
            .timer_irq (timer_irq[d])
        );

        // RAM with LAT-stage read pipeline; junk flows through when no read is issued
        assign ram_rdata[d] = pipe[LAT-1];
        always @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < 1024; i++) mem[i] <= '0;
            end else if (ram_en[d]) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[d][b]) mem[ram_addr[d]][8*b +: 8] <= ram_wdata[d][8*b +: 8];
            end
            pipe[0] <= (ram_en[d] && ram_we[d] == 4'b0000) ? mem[ram_addr[d]] : $urandom;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // reference model state
    logic [31:0] m_mem     [2][1024];
    logic [7:0]  m_gpio_out[2];
    logic [7:0]  m_gpio_in [2];

    // results of the last request
    int          r_lat, r_en_cnt, r_en_cyc, r_acc;
    logic [31:0] r_rdata, r_wd;
    logic        r_err, r_irq;
    logic [3:0]  r_we;
    logic [9:0]  r_addr;
    logic [7:0]  r_gpio;

    task automatic do_req(input int d, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        int guard;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        req_be[d]    = be;
        req_wdata[d] = wd;
        guard = 0;
        while (!req_ready[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_wait", 32'(req_ready[d]), 32'd1);
        r_acc = cyc + 1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_be[d]    = 4'($urandom);
        req_wdata[d] = $urandom;
        r_lat = 0; r_en_cnt = 0; r_en_cyc = 0; r_rdata = '0; r_err = 1'b0;
        r_we = '0; r_addr = '0; r_wd = '0; r_irq = 1'b0; r_gpio = '0;
        for (int c = 1; c <= 12; c++) begin
            if (ram_en[d]) begin
                r_en_cnt++;
                r_en_cyc = c;
                r_we     = ram_we[d];
                r_addr   = ram_addr[d];
                r_wd     = ram_wdata[d];
            end
            if (resp_valid[d]) begin
                r_lat   = c;
                r_rdata = resp_rdata[d];
                r_err   = resp_err[d];
                r_irq   = timer_irq[d];
                r_gpio  = gpio_out[d];
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid[d]), 32'd0);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // GPIO and RAM transaction checked against the model; timer registers are handled directly
    task automatic txn(input int d, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                       input string tag);
        logic [31:0] er;
        logic        ee, is_ram, gpio_wr;
        int          el;
        logic [11:0] off;
        er = '0; ee = 1'b0; gpio_wr = 1'b0;
        off    = {a[11:2], 2'b00};
        is_ram = a < 32'h0000_1000;
        if (is_ram) begin
            el = (be != 4'b0000) ? 2 : 2 + ((d == 0) ? LAT0 : LAT1);
            if (be == 4'b0000) er = m_mem[d][a[11:2]];
            else m_mem[d][a[11:2]] = merge(m_mem[d][a[11:2]], wd, be);
        end else begin
            el = 1;
            if (a[31:12] != 20'h10000) ee = 1'b1;
            else if (off == 12'h000) begin
                if (be == 4'b0000) er = {24'd0, m_gpio_out[d]};
                else if (be[0]) m_gpio_out[d] = wd[7:0];
                gpio_wr = be != 4'b0000;
            end else if (off == 12'h004) begin
                if (be == 4'b0000) er = {24'd0, m_gpio_in[d]};
            end else ee = 1'b1;
        end
        do_req(d, a, be, wd);
        chk({tag, "_lat"},   32'(r_lat), 32'(el));
        chk({tag, "_rdata"}, r_rdata, er);
        chk({tag, "_err"},   32'(r_err), 32'(ee));
        if (is_ram) begin
            chk({tag, "_ram_en_cnt"}, 32'(r_en_cnt), 32'd1);
            chk({tag, "_ram_en_cyc"}, 32'(r_en_cyc), 32'd1);
            chk({tag, "_ram_we"},     32'(r_we), 32'(be));
            chk({tag, "_ram_addr"},   32'(r_addr), 32'(a[11:2]));
            if (be != 4'b0000) chk({tag, "_ram_wdata"}, r_wd, wd);
        end else begin
            chk({tag, "_no_ram_en"}, 32'(r_en_cnt), 32'd0);
        end
        if (gpio_wr) chk({tag, "_gpio_at_resp"}, 32'(r_gpio), 32'(m_gpio_out[d]));
    endtask

    initial begin
        int          t0;
        logic [31:0] exp_v;
        logic [31:0] a;
        logic [3:0]  be;
        int          op;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_addr[d] = '0; req_be[d] = '0; req_wdata[d] = '0;
            gpio_in[d] = '0; m_gpio_in[d] = '0; m_gpio_out[d] = '0;
            for (int i = 0; i < 1024; i++) m_mem[d][i] = '0;
        end

        repeat (3) @(negedge clk);
        chk("rst_req_ready",  32'(req_ready[0]), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("rst_ram_en",     32'(ram_en[0]), 32'd0);
        chk("rst_gpio_out",   32'(gpio_out[0]), 32'd0);
        chk("rst_timer_irq",  32'(timer_irq[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(req_ready[0]), 32'd1);

        // RAM basic write/read and byte-lane write, LAT=1 and LAT=3
        for (int d = 0; d < 2; d++) begin
            txn(d, 32'h0000_0040, 4'hF, 32'hDEAD_BEEF, "ram_wr");
            txn(d, 32'h0000_0040, 4'h0, 32'h0,         "ram_rd");
            txn(d, 32'h0000_0040, 4'h2, 32'h0000_AB00, "ram_wr_lane");
            txn(d, 32'h0000_0040, 4'h0, 32'h0,         "ram_rd_lane");
            chk("ram_rd_lane_value", r_rdata, 32'hDEAD_ABEF);
            txn(d, 32'h0000_0FFC, 4'hF, 32'h1234_5678, "ram_top_wr");
            txn(d, 32'h0000_0FFC, 4'h0, 32'h0,         "ram_top_rd");
            txn(d, 32'h0000_1000, 4'h0, 32'h0,         "above_ram");
        end

        // GPIO
        txn(0, 32'h1000_0000, 4'hF, 32'h0000_00A5, "gpio_wr");
        chk("gpio_a5_resp", 32'(r_gpio), 32'h0000_00A5);
        gpio_in[0] = 8'h3C; m_gpio_in[0] = 8'h3C;
        repeat (3) @(negedge clk);
        txn(0, 32'h1000_0004, 4'h0, 32'h0, "gpio_in_rd");
        txn(0, 32'h1000_0004, 4'hF, 32'hFFFF_FFFF, "gpio_in_ro_wr");
        txn(0, 32'h1000_0000, 4'h0, 32'h0, "gpio_out_rd");

        // errors
        txn(0, 32'h2000_0000, 4'h0, 32'h0, "err_unmapped");
        txn(0, 32'h1000_0020, 4'h0, 32'h0, "err_offset");
        txn(0, 32'h1000_0014, 4'hF, 32'hFFFF_FFFF, "err_offset_wr");

        // timer
        do_req(0, 32'h1000_000C, 4'hF, 32'd5);
        do_req(0, 32'h1000_0008, 4'hF, 32'd0);
        do_req(0, 32'h1000_0010, 4'hF, 32'd1);
        t0 = r_acc;
        for (int i = 0; i < 20 && !timer_irq[0]; i++) @(negedge clk);
        chk("irq_rise_cycle", 32'(cyc - t0), 32'd6);
        do_req(0, 32'h1000_0010, 4'hF, 32'd3);
        chk("irq_w1c_resp", 32'(r_irq), 32'd0);
        do_req(0, 32'h1000_0010, 4'h0, 32'd0);
        chk("ctrl_after_w1c", r_rdata, 32'd1);
        do_req(0, 32'h1000_000C, 4'hF, 32'h8000_0000);
        do_req(0, 32'h1000_0008, 4'hF, 32'hFFFF_FFFF);
        t0 = r_acc;
        do_req(0, 32'h1000_0008, 4'h0, 32'd0);
        exp_v = 32'hFFFF_FFFF + 32'(r_acc - 1 - t0);
        chk("cnt_wrap", r_rdata, exp_v);
        do_req(0, 32'h1000_0010, 4'hF, 32'd0);
        do_req(0, 32'h1000_0010, 4'h0, 32'd0);
        chk("ctrl_disabled", r_rdata, 32'd0);
        chk("irq_idle", 32'(timer_irq[0]), 32'd0);

        // randomized traffic
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < ((d == 0) ? 80 : 30); n++) begin
                op = $urandom_range(0, 6);
                a  = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
                be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                case (op)
                    0, 1: txn(d, a, 4'($urandom_range(1, 15)), $urandom, "rnd_ram_wr");
                    2, 3: txn(d, a, 4'h0, 32'h0, "rnd_ram_rd");
                    4: txn(d, 32'h1000_0000 | 32'($urandom_range(0, 3)), be, $urandom, "rnd_gpio_out");
                    5: begin
                        gpio_in[d] = 8'($urandom); m_gpio_in[d] = gpio_in[d];
                        repeat (3) @(negedge clk);
                        txn(d, 32'h1000_0004, be, $urandom, "rnd_gpio_in");
                    end
                    default: begin
                        if ($urandom_range(0, 1) == 0)
                            txn(d, 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF), be, $urandom, "rnd_err_addr");
                        else
                            txn(d, 32'h1000_0014 + 32'(4 * $urandom_range(0, 1000)), be, $urandom, "rnd_err_off");
                    end
                endcase
            end
        end

        // reset while a LAT=3 read sits in WAIT
        @(negedge clk);
        req_valid[1] = 1'b1; req_addr[1] = 32'h0000_0080; req_be[1] = 4'h0;
        chk("rst_test_ready", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_resp_valid", 32'(resp_valid[1]), 32'd0);
        chk("rst_wait_ready",      32'(req_ready[1]), 32'd0);
        chk("rst_wait_rdata",      resp_rdata[1], 32'd0);
        chk("rst_wait_ram_en",     32'(ram_en[1]), 32'd0);
        chk("rst_wait_gpio",       32'(gpio_out[1]), 32'd0);
        chk("rst_wait_gpio0",      32'(gpio_out[0]), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_resp", 32'(resp_valid[1]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 32'(req_ready[1]), 32'd1);
        repeat (6) begin
            chk("rst_no_resp", 32'(resp_valid[1]), 32'd0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
